arb_rr_bin: RTL and testbench
=============================

Name: arb_rr_bin

Overview:
Round-robin arbiter that produces a registered binary select index for the binary-select multiplexer stage directly downstream. It picks one of WIDTH requesters, presents the winner's index on `bin` with a valid/ready handshake, and holds the index stable until the consumer accepts it. Throughput is one grant per cycle under continuous demand.

Parameters:
- WIDTH, 16, number of requesters; the multiplexer input count downstream.
- SPLIT, 4, fan-in of each node in the priority-search tree. Structural only; must not change cycle behaviour.
- WIDTH_LOG, $clog2(WIDTH), width of the binary index (localparam).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  WIDTH  request vector; bit i means requester i wants a grant.
- vld  output  1  grant valid.
- rdy  input  1  consumer ready; a transfer happens on any clock edge where vld&&rdy.
- bin  output  WIDTH_LOG  binary index of the granted requester; drives the mux select.
- gnt  output  WIDTH  one-hot decode of bin, gated by vld (all zero when vld=0).

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - vld=0, bin=0, gnt=0.
  - Priority pointer ptr=0.
  - State=IDLE.
- State machine has two states: IDLE (vld=0) and GRANT (vld=1).
- Arbitration function:
  - Search for the first i with req[i]=1, scanning from ptr upward.
  - Wrap from WIDTH-1 to 0; the search covers all WIDTH bits.
  - Implement as a tree of SPLIT-wide nodes.
- IDLE, |req=0: stay in IDLE; bin holds its last value.
- IDLE, |req=1: on the next edge go to GRANT, set bin to the arbitration result, vld=1. Latency from req to vld is 1 cycle.
- GRANT, rdy=0 (backpressure):
  - bin, vld and gnt stay frozen.
  - Changes on req are ignored, including deassertion of the granted bit. A grant, once issued, is sticky.
- GRANT, rdy=1 (transfer):
  - ptr becomes (bin+1) mod WIDTH. When bin=WIDTH-1, ptr becomes 0.
  - In the same cycle, arbitration is re-evaluated on the current req using the new pointer.
  - If any req bit is set: stay in GRANT with the new bin, giving back-to-back grants.
  - If no req bit is set: go to IDLE, vld=0.
  - The just-granted requester may win again only if it is the only requester.
- ptr changes only on a transfer, never while in IDLE or under backpressure.
- Non-power-of-2 WIDTH:
  - bin never exceeds WIDTH-1.
  - ptr wraps at WIDTH, not 2^WIDTH_LOG.
- WIDTH=1: bin is 1 bit wide and always 0; vld tracks req[0] with one cycle of latency, subject to the sticky rule.
- Reset asserted mid-GRANT: the outstanding grant is dropped with no transfer, and ptr returns to 0.
- No combinational path from req or rdy to any output.

Optional Feature:
- Macro: ARB_RR_BIN_LOCK_EN.
- When defined:
  - Adds input port lck (1 bit).
  - On a transfer with lck=1 and req[bin] still 1: the next grant is the same bin, ptr is not advanced, and the block stays in GRANT. This supports multi-beat packets.
  - On a transfer with lck=1 and req[bin]=0: normal arbitration.
  - lck is sampled only on transfer edges.
- When undefined: no lck port; behaviour is identical to lck=0.

Test Plan (WIDTH=16, SPLIT=4):
- Reset, req=16'h0000, rdy=1 for 10 cycles -> vld=0, bin=0, gnt=0 throughout.
- Single requester:
  - Stimulus: req=16'h0020, rdy=1.
  - Response: vld=1 one cycle later, bin=5, gnt=16'h0020 every cycle.
  - Then req=0 -> vld=0 on the edge after the next transfer.
- Full fairness: req=16'hFFFF, rdy=1 continuous -> bin=0,1,2,…,15,0,1 on consecutive cycles with no gaps.
- Backpressure and sticky grant:
  - req=16'h0090, rdy=0 -> bin=4 held.
  - Change req to 16'h0080 and hold rdy=0 for 5 cycles -> bin stays 4.
  - Assert rdy=1 -> transfer of 4, next bin=7.
- Wrap-around:
  - After a grant of bin=15, req=16'h8001 -> next bin=0.
  - After that transfer -> bin=15.
- Async reset mid-grant: vld=1, bin=9, then rst_n low between edges -> vld=0, bin=0 immediately. After release with req=16'h0300 -> bin=8, since ptr=0.
- (ARB_RR_BIN_LOCK_EN) req=16'h0006, lck=1 for 3 transfers -> bin=1,1,1,1. Then lck=0 -> bin=2.

Source files
------------

// File: rtl/arb_rr_bin.sv
// Round-robin arbiter with a registered binary grant index and valid/ready handshake.
// Optional packet lock (input lck) is enabled by defining ARB_RR_BIN_LOCK_EN.
module arb_rr_bin #(
  parameter int WIDTH = 16,
  parameter int SPLIT = 4,
  localparam int WIDTH_LOG = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req,
  output logic                 vld,
  input  logic                 rdy,
`ifdef ARB_RR_BIN_LOCK_EN
  input  logic                 lck,
`endif
  output logic [WIDTH_LOG-1:0] bin,
  output logic [WIDTH-1:0]     gnt
);

  function automatic int calc_lvl(input int w, input int s);
    int l;
    int p;
    l = 1;
    p = s;
    while (p < w) begin
      p = p * s;
      l = l + 1;
    end
    return l;
  endfunction

  // Search tree is padded up to a full SPLIT-ary tree; padding bits never request.
  localparam int LVL = calc_lvl(WIDTH, SPLIT);
  localparam int PW  = SPLIT ** LVL;
  localparam int IW  = $clog2(PW);

  typedef enum logic {IDLE, GRANT} state_t;

  typedef struct packed {
    logic          found;
    logic [IW-1:0] idx;
  } ffs_t;

  // Lowest set bit of v, found by SPLIT-wide nodes combined level by level.
  function automatic ffs_t ffs_tree(input logic [PW-1:0] v);
    logic          nv [LVL+1][PW];
    logic [IW-1:0] ni [LVL+1][PW];
    ffs_t          r;
    for (int n = 0; n < PW; n++) begin
      nv[0][n] = v[n];
      ni[0][n] = '0;
    end
    for (int l = 1; l <= LVL; l++) begin
      for (int n = 0; n < PW; n++) begin
        nv[l][n] = 1'b0;
        ni[l][n] = '0;
        if (n < PW / (SPLIT ** l)) begin
          for (int c = SPLIT - 1; c >= 0; c--) begin
            if (nv[l-1][n*SPLIT+c]) begin
              nv[l][n] = 1'b1;
              ni[l][n] = IW'(c * (SPLIT ** (l - 1))) + ni[l-1][n*SPLIT+c];
            end
          end
        end
      end
    end
    r.found = nv[LVL][0];
    r.idx   = ni[LVL][0];
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [WIDTH_LOG-1:0] bin_q, bin_d;
  logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]     gnt_q, gnt_d;

  logic [WIDTH_LOG-1:0] ptr_nxt, ptr_srch, arb_idx;
  logic [PW-1:0]        req_pad, req_msk;
  ffs_t                 hit_msk, hit_all;
  logic                 lock_hold;

  // Pointer after a transfer wraps at WIDTH, not at 2**WIDTH_LOG.
  assign ptr_nxt  = (bin_q == WIDTH_LOG'(WIDTH - 1)) ? '0 : bin_q + 1'b1;
  assign ptr_srch = (state_q == GRANT) ? ptr_nxt : ptr_q;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    req_pad = '0;
    req_msk = '0;
    for (int i = 0; i < WIDTH; i++) begin
      req_pad[i] = req[i];
      req_msk[i] = req[i] && (WIDTH_LOG'(i) >= ptr_srch);
    end
  end

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  assign hit_msk = ffs_tree(req_msk);
  assign hit_all = ffs_tree(req_pad);
  assign arb_idx = hit_msk.found ? WIDTH_LOG'(hit_msk.idx) : WIDTH_LOG'(hit_all.idx);

`ifdef ARB_RR_BIN_LOCK_EN
  assign lock_hold = lck && req[bin_q];
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          bin_d   = arb_idx;
        end
      end
      GRANT: begin
        // Under backpressure everything is frozen; req is only looked at on a transfer.
        if (rdy && !lock_hold) begin
          ptr_d = ptr_nxt;
          if (|req) bin_d = arb_idx;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = '0;
    if (state_d == GRANT) gnt_d[bin_d] = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  assign vld = (state_q == GRANT);
  assign bin = bin_q;
  assign gnt = gnt_q;

endmodule

// File: tb/tb_arb_rr_bin.sv
// Directed-vector bench for arb_rr_bin (WIDTH=16, SPLIT=4); lock scenario runs
// only when ARB_RR_BIN_LOCK_EN is defined.
module tb_arb_rr_bin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        rdy;
  logic        lck;
  logic        vld;
  logic [3:0]  bin;
  logic [15:0] gnt;

  int n_vec = 0;
  int n_err = 0;

  arb_rr_bin #(.WIDTH(16), .SPLIT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .vld  (vld),
    .rdy  (rdy),
`ifdef ARB_RR_BIN_LOCK_EN
    .lck  (lck),
`endif
    .bin  (bin),
    .gnt  (gnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  // Compares all three outputs against a hand-computed grant state.
  task automatic expect_out(input string name, input logic e_vld, input logic [3:0] e_bin);
    logic [15:0] e_gnt;
    e_gnt = e_vld ? (16'h0001 << e_bin) : 16'h0000;
    n_vec++;
    if (vld !== e_vld || bin !== e_bin || gnt !== e_gnt) begin
      n_err++;
      $display("FAIL %s: got vld=%0b bin=%0d gnt=%h, want vld=%0b bin=%0d gnt=%h",
               name, vld, bin, gnt, e_vld, e_bin, e_gnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 16'h0000; rdy = 1'b1; lck = 1'b0;
    #3;
    expect_out("reset_async", 1'b0, 4'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out("reset_idle", 1'b0, 4'd0);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 16'h0020; rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("single_req5", 1'b1, 4'd5);
    end
    req = 16'h0000;
    tick();
    expect_out("single_drop", 1'b0, 4'd5);
    tick();
    expect_out("idle_hold_bin", 1'b0, 4'd5);
    // Pointer sits at 6 after granting 5, so the search wraps to bit 0.
    req = 16'h0021;
    tick();
    expect_out("ptr_kept_in_idle", 1'b1, 4'd0);
    req = 16'h0000;
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    req = 16'hFFFF; rdy = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      expect_out("fair_rotate", 1'b1, 4'(i % 16));
    end
    req = 16'h0000;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [4] = '{4'd1, 4'd2, 4'd1, 4'd2};
    do_reset();
    req = 16'h0006; rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("b2b_pair", 1'b1, seq[i]);
    end
    req = 16'h0000;
    tick();
    expect_out("b2b_idle", 1'b0, 4'd2);
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 16'h0090; rdy = 1'b0;
    tick();
    expect_out("bp_first", 1'b1, 4'd4);
    req = 16'h0080;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("bp_sticky", 1'b1, 4'd4);
    end
    rdy = 1'b1;
    tick();
    expect_out("bp_release", 1'b1, 4'd7);
    req = 16'h0000;
    tick();
    expect_out("bp_idle", 1'b0, 4'd7);
  endtask

  task automatic test_wrap();
    do_reset();
    req = 16'h8000; rdy = 1'b0;
    tick();
    expect_out("wrap_top", 1'b1, 4'd15);
    req = 16'h8001; rdy = 1'b1;
    tick();
    expect_out("wrap_to0", 1'b1, 4'd0);
    tick();
    expect_out("wrap_to15", 1'b1, 4'd15);
    req = 16'h0000;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 16'h0200; rdy = 1'b0;
    tick();
    expect_out("ar_grant9", 1'b1, 4'd9);
    #2 rst_n = 1'b0;
    #1;
    expect_out("ar_dropped", 1'b0, 4'd0);
    req = 16'h0300;
    #1 rst_n = 1'b1;
    tick();
    expect_out("ar_ptr_zero", 1'b1, 4'd8);
    req = 16'h0000; rdy = 1'b1;
    tick();
  endtask

`ifdef ARB_RR_BIN_LOCK_EN
  task automatic test_lock();
    do_reset();
    req = 16'h0006; rdy = 1'b1; lck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("lock_hold", 1'b1, 4'd1);
    end
    lck = 1'b0;
    tick();
    expect_out("lock_release", 1'b1, 4'd2);
    req = 16'h0000;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_async_reset();
`ifdef ARB_RR_BIN_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
